// File: rtl/autotest_pkg.sv
// Shared types and constants for the autotest run sequencer.
package autotest_pkg;

    // Run sequencer states, in the order a normal run visits them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SET_CLK   = 3'd1,
        RST_UUT   = 3'd2,
        WAIT_IDLE = 3'd3,
        START     = 3'd4,
        RUN       = 3'd5,
        DONE      = 3'd6
    } seq_state_t;

    // Result codes reported on run_status.
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    // UUT clock select used out of reset (fastest clock).
    localparam logic [1:0] CLK_SEL_MAX = 2'b10;

endpackage

// File: rtl/uut_run_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer bringing a UUT-domain flag into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back captures; only r_sync is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uut_run_sequencer.sv
// Sequences one measured UUT run: clock select, settle, reset pulse,
// start handshake and cycle counting until end, error, timeout or abort.
module uut_run_sequencer
    import autotest_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             abort,
    input  logic [1:0]       clk_sel_req,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic             run_busy,
    output logic             run_done,
    output logic [1:0]       run_status,
    output logic [CNT_W-1:0] cycle_count,
    output logic             rst_uut,
    output logic             start_uut,
    output logic             ctrl_mux_uut,
    output logic [1:0]       clk_uut_sel,
    input  logic             end_uut,
    input  logic             err_uut,
    input  logic             busy_uut
);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_status;
    logic [1:0]       r_clk_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_rst_uut;
    logic             r_start;
    logic             r_mux;

    logic             w_end_s;
    logic             w_err_s;
    logic             w_busy_s;
    logic             w_run_to;
    logic             w_wait_to;
    logic             w_term;
    logic [1:0]       w_term_status;

    sync_2ff u_sync_end  (.clk(clk), .rst(rst), .i_d(end_uut),  .o_q(w_end_s));
    sync_2ff u_sync_err  (.clk(clk), .rst(rst), .i_d(err_uut),  .o_q(w_err_s));
    sync_2ff u_sync_busy (.clk(clk), .rst(rst), .i_d(busy_uut), .o_q(w_busy_s));

    // A zero limit disables the timeout; the WAIT_IDLE phase reuses r_phase.
    assign w_run_to  = (r_limit != CNT_ZERO) && (r_count == (r_limit - CNT_ONE));
    assign w_wait_to = (r_limit != CNT_ZERO) && (r_phase == (r_limit - CNT_ONE));

    // Terminating-event decode, priority abort > error > end > timeout.
    always_comb begin
        w_term        = 1'b0;
        w_term_status = ST_OK;
        case (r_state)
            SET_CLK, RST_UUT: begin
                if (abort) begin
                    w_term = 1'b1; w_term_status = ST_ABORT;
                end else begin
                    w_term = 1'b0; w_term_status = ST_OK;
                end
            end
            WAIT_IDLE: begin
                if (abort) begin
                    w_term = 1'b1; w_term_status = ST_ABORT;
                end else if (w_busy_s && w_wait_to) begin
                    w_term = 1'b1; w_term_status = ST_TIMEOUT;
                end else begin
                    w_term = 1'b0; w_term_status = ST_OK;
                end
            end
            START: begin
                if (abort) begin
                    w_term = 1'b1; w_term_status = ST_ABORT;
                end else if (w_err_s) begin
                    w_term = 1'b1; w_term_status = ST_ERR;
                end else if (!(w_busy_s || w_end_s) && w_run_to) begin
                    // UUT never acknowledged the start within the limit
                    w_term = 1'b1; w_term_status = ST_TIMEOUT;
                end else begin
                    w_term = 1'b0; w_term_status = ST_OK;
                end
            end
            RUN: begin
                if (abort) begin
                    w_term = 1'b1; w_term_status = ST_ABORT;
                end else if (w_err_s) begin
                    w_term = 1'b1; w_term_status = ST_ERR;
                end else if (w_end_s) begin
                    w_term = 1'b1; w_term_status = ST_OK;
                end else if (w_run_to) begin
                    w_term = 1'b1; w_term_status = ST_TIMEOUT;
                end else begin
                    w_term = 1'b0; w_term_status = ST_OK;
                end
            end
            default: begin
                w_term = 1'b0; w_term_status = ST_OK;
            end
        endcase
    end

    // Sequencer FSM with phase/cycle counters and registered UUT controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_phase   <= CNT_ZERO;
            r_limit   <= CNT_ZERO;
            r_count   <= CNT_ZERO;
            r_status  <= ST_OK;
            r_clk_sel <= CLK_SEL_MAX;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rst_uut <= 1'b1;
            r_start   <= 1'b0;
            r_mux     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_term) begin
                r_state   <= DONE;
                r_status  <= w_term_status;
                r_done    <= 1'b1;
                r_rst_uut <= 1'b1;
                r_start   <= 1'b0;
                r_mux     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_busy    <= 1'b0;
                        r_rst_uut <= 1'b1;
                        r_start   <= 1'b0;
                        r_mux     <= 1'b0;
                        if (run_req && !abort) begin
                            r_limit   <= timeout_limit;
                            r_clk_sel <= clk_sel_req;
                            r_count   <= CNT_ZERO;
                            r_status  <= ST_OK;
                            r_phase   <= CNT_ZERO;
                            r_busy    <= 1'b1;
                            r_state   <= SET_CLK;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    SET_CLK: begin
                        if (r_phase == SETTLE_LAST) begin
                            r_phase <= CNT_ZERO;
                            r_state <= RST_UUT;
                        end else begin
                            r_phase <= r_phase + CNT_ONE;
                        end
                    end
                    RST_UUT: begin
                        if (r_phase == RST_LAST) begin
                            r_phase   <= CNT_ZERO;
                            r_rst_uut <= 1'b0;
                            r_mux     <= 1'b1;
                            r_state   <= WAIT_IDLE;
                        end else begin
                            r_phase <= r_phase + CNT_ONE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (!w_busy_s) begin
                            r_start <= 1'b1;
                            r_state <= START;
                        end else if (r_phase != CNT_MAX) begin
                            r_phase <= r_phase + CNT_ONE;
                        end else begin
                            r_phase <= r_phase;
                        end
                    end
                    START, RUN: begin
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + CNT_ONE;
                        end else begin
                            r_count <= r_count;
                        end
                        if ((r_state == START) && (w_busy_s || w_end_s)) begin
                            r_start <= 1'b0;
                            r_state <= RUN;
                        end else begin
                            r_state <= r_state;
                        end
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_busy    <= 1'b0;
                        r_rst_uut <= 1'b1;
                        r_start   <= 1'b0;
                        r_mux     <= 1'b0;
                        r_state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign run_busy     = r_busy;
    assign run_done     = r_done;
    assign run_status   = r_status;
    assign cycle_count  = r_count;
    assign rst_uut      = r_rst_uut;
    assign start_uut    = r_start;
    assign ctrl_mux_uut = r_mux;
    assign clk_uut_sel  = r_clk_sel;

endmodule

// File: tb/tb_uut_run_sequencer.sv
// Scoreboard bench for uut_run_sequencer: stimulus pushes expected run
// results computed from an event-time model; a monitor checks each run_done.
module tb_uut_run_sequencer;

    localparam int NEVER = 1000000;
    localparam int PRE   = 25;          // edges from run_req sample to START entry

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_req = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  clk_sel_req = 2'b00;
    logic [31:0] timeout_limit = 32'd0;
    logic        run_busy, run_done, rst_uut, start_uut, ctrl_mux_uut;
    logic [1:0]  run_status, clk_uut_sel;
    logic [31:0] cycle_count;
    logic        end_uut = 1'b0, err_uut = 1'b0, busy_uut = 1'b0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cnt;
        int          cyc;
        logic [1:0]  sel;
    } exp_t;

    exp_t sbq[$];
    exp_t mx;
    int   cyc = 0;
    int   start_hi = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    uut_run_sequencer #(.RST_CYCLES(16), .SETTLE_CYCLES(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst_n), .run_req(run_req), .abort(abort),
        .clk_sel_req(clk_sel_req), .timeout_limit(timeout_limit),
        .run_busy(run_busy), .run_done(run_done), .run_status(run_status),
        .cycle_count(cycle_count), .rst_uut(rst_uut), .start_uut(start_uut),
        .ctrl_mux_uut(ctrl_mux_uut), .clk_uut_sel(clk_uut_sel),
        .end_uut(end_uut), .err_uut(err_uut), .busy_uut(busy_uut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Event-time model, offsets relative to START entry. A synchronized UUT
    // flag driven after edge x is acted on at edge x+3 with count x+2; abort
    // driven after edge x is acted on at x+1. Lower priority applied first,
    // so ties go to the higher-priority event.
    function automatic void model(input int b, input int e, input int r, input int a,
                                  input int lim, output logic [1:0] st, output int t);
        t  = NEVER;
        st = 2'b00;
        if (lim != 0)                     begin t = lim;   st = 2'b10; end
        if (e != NEVER && e + 3 <= t)     begin t = e + 3; st = 2'b00; end
        if (r != NEVER && r + 3 <= t)     begin t = r + 3; st = 2'b01; end
        if (a != NEVER && a + 1 <= t)     begin t = a + 1; st = 2'b11; end
        if (b == NEVER && t == NEVER)     t = 0;
    endfunction

    task automatic do_run(input logic [1:0] sel, input int lim, input int b,
                          input int e, input int r, input int a);
        int         e0, es, t, k, s0;
        logic [1:0] st;
        exp_t       x;
        model(b, e, r, a, lim, st, t);
        step();
        run_req = 1'b1; clk_sel_req = sel; timeout_limit = 32'(lim);
        step();
        e0 = cyc; es = e0 + PRE;
        run_req = 1'b0;
        clk_sel_req = 2'($urandom_range(0, 3));
        timeout_limit = $urandom;
        x.st = st; x.cnt = (t > 0) ? 32'(t - 1) : 32'd0; x.cyc = es + t; x.sel = sel;
        sbq.push_back(x);
        s0 = start_hi;
        while ((cyc - es) < t + 2) begin
            step();
            k = cyc - es;
            if (k == b) busy_uut = 1'b1;
            if (k == e) end_uut = 1'b1;
            if (k == r) err_uut = 1'b1;
            if (k == a) abort = 1'b1;
            if (k == a + 1) abort = 1'b0;
            if (a >= 0) begin
                if (k == -24) begin
                    chk("sel_applied", 64'(clk_uut_sel), 64'(sel));
                    chk("busy_in_run", 64'(run_busy), 64'd1);
                end
                if (k == -2) chk("rst_held", 64'(rst_uut), 64'd1);
                if (k == -1) begin
                    chk("rst_released", 64'(rst_uut), 64'd0);
                    chk("mux_run", 64'(ctrl_mux_uut), 64'd1);
                end
                if (k == 0) chk("start_high", 64'(start_uut), 64'd1);
                if (b != NEVER && k == b + 3 && b + 3 < t) chk("start_dropped", 64'(start_uut), 64'd0);
            end
        end
        busy_uut = 1'b0; end_uut = 1'b0; err_uut = 1'b0; abort = 1'b0;
        chk("idle_after_done", 64'(run_busy), 64'd0);
        chk("done_seen", 64'(sbq.size()), 64'd0);
        if (a < 0) chk("no_start", 64'(start_hi - s0), 64'd0);
        repeat (4) step();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s0;
        fork
            forever begin
                @(negedge clk);
                if (start_uut) start_hi++;
                if (rst_n && run_done) begin
                    chk("done_expected", 64'(sbq.size() != 0), 64'd1);
                    if (sbq.size() != 0) begin
                        mx = sbq.pop_front();
                        chk("status", 64'(run_status), 64'(mx.st));
                        chk("cycle_count", 64'(cycle_count), 64'(mx.cnt));
                        chk("done_cycle", 64'(cyc), 64'(mx.cyc));
                        chk("done_sel", 64'(clk_uut_sel), 64'(mx.sel));
                        chk("done_rst_uut", 64'(rst_uut), 64'd1);
                        chk("done_mux", 64'(ctrl_mux_uut), 64'd0);
                        chk("done_start", 64'(start_uut), 64'd0);
                    end
                end
            end
        join_none

        // Reset values
        step(); step();
        chk("rst_busy", 64'(run_busy), 64'd0);
        chk("rst_done", 64'(run_done), 64'd0);
        chk("rst_status", 64'(run_status), 64'd0);
        chk("rst_count", 64'(cycle_count), 64'd0);
        chk("rst_rst_uut", 64'(rst_uut), 64'd1);
        chk("rst_start", 64'(start_uut), 64'd0);
        chk("rst_mux", 64'(ctrl_mux_uut), 64'd0);
        chk("rst_sel", 64'(clk_uut_sel), 64'd2);
        rst_n = 1'b1;
        repeat (3) step();

        // Nominal, error, timeout, abort in RST_UUT, simultaneous events
        do_run(2'b10, 0, 5, 105, NEVER, NEVER);
        do_run(2'b01, 0, 5, NEVER, 48, NEVER);
        do_run(2'b00, 50, 5, NEVER, NEVER, NEVER);
        do_run(2'b11, 0, NEVER, NEVER, NEVER, -15);
        do_run(2'b10, 0, 5, 20, 20, NEVER);
        do_run(2'b01, 0, 5, 30, NEVER, 32);

        // Timeout while the UUT never goes idle after reset release
        busy_uut = 1'b1;
        repeat (3) step();
        run_req = 1'b1; clk_sel_req = 2'b01; timeout_limit = 32'd5;
        step();
        e0 = cyc; run_req = 1'b0;
        mx.st = 2'b10; mx.cnt = 32'd0; mx.cyc = e0 + 29; mx.sel = 2'b01;
        sbq.push_back(mx);
        s0 = start_hi;
        while (cyc < e0 + 31) step();
        chk("wait_to_seen", 64'(sbq.size()), 64'd0);
        chk("wait_to_no_start", 64'(start_hi - s0), 64'd0);
        busy_uut = 1'b0;
        repeat (4) step();

        // Randomized runs
        for (int i = 0; i < 6; i++) begin
            int rb, re, rr, rl;
            rb = int'($urandom_range(1, 10));
            re = rb + int'($urandom_range(3, 60));
            rr = ($urandom_range(0, 2) == 0) ? rb + int'($urandom_range(3, 60)) : NEVER;
            rl = ($urandom_range(0, 1) == 0) ? 0 : rb + int'($urandom_range(5, 80));
            do_run(2'($urandom_range(0, 3)), rl, rb, re, rr, NEVER);
        end

        // Asynchronous reset in the middle of RUN, then a clean run
        step();
        run_req = 1'b1; clk_sel_req = 2'b01; timeout_limit = 32'd0;
        step();
        e0 = cyc; run_req = 1'b0;
        while (cyc < e0 + PRE + 20) begin
            step();
            if (cyc == e0 + PRE + 5) busy_uut = 1'b1;
        end
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", 64'(run_busy), 64'd0);
        chk("mid_rst_rst_uut", 64'(rst_uut), 64'd1);
        chk("mid_rst_start", 64'(start_uut), 64'd0);
        chk("mid_rst_mux", 64'(ctrl_mux_uut), 64'd0);
        chk("mid_rst_sel", 64'(clk_uut_sel), 64'd2);
        chk("mid_rst_count", 64'(cycle_count), 64'd0);
        step();
        rst_n = 1'b1; busy_uut = 1'b0;
        repeat (4) step();
        chk("mid_rst_idle", 64'(run_busy), 64'd0);
        do_run(2'b11, 0, 5, 105, NEVER, NEVER);

        chk("sb_empty_end", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
